// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding and
// the bit-counter width helper.
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter width is clog2(width), never less than one bit.
    function automatic int cnt_w_f(input int width);
        if (width <= 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/bit_serial_adder_fa.sv
// Full-adder cell that also exposes the bit propagate, so the controller can
// build the group propagate alongside the sum.
module fa_p_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic p,
    output logic cout
);

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (p & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: streams operands LSB-first through one fa_p_cell
// under a start/done handshake and holds sum, carry-out and group propagate.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             p_all
);

    localparam int             CNT_W    = cnt_w_f(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r, state_nx_s;
    logic             load_s, last_s;
    logic [WIDTH-1:0] a_r, b_r, work_r, work_nx_s, sum_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r, p_acc_r, cout_r, p_all_r, busy_r, done_r;
    logic             s_s, p_s, c_s;

    fa_p_cell u_cell (
        .a   (a_r[0]),
        .b   (b_r[0]),
        .cin (carry_r),
        .s   (s_s),
        .p   (p_s),
        .cout(c_s)
    );

    // New sum bit enters at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_work_1
            assign work_nx_s = s_s;
        end else begin : g_work_n
            assign work_nx_s = {s_s, work_r[WIDTH-1:1]};
        end
    endgenerate

    assign last_s = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);

    // Next-state decode; a start is only accepted in IDLE or DONE.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_SHIFT;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nx_s = ST_SHIFT;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ST_SHIFT);
            done_r  <= (state_nx_s == ST_DONE);
        end
    end

    // Operand shift registers, carry, propagate accumulator and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            work_r  <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            p_acc_r <= 1'b0;
        end else if (load_s) begin
            a_r     <= a;
            b_r     <= b;
            work_r  <= '0;
            cnt_r   <= '0;
            carry_r <= cin;
            p_acc_r <= 1'b1;
        end else if (state_r == ST_SHIFT) begin
            a_r     <= a_r >> 1'b1;
            b_r     <= b_r >> 1'b1;
            work_r  <= work_nx_s;
            cnt_r   <= cnt_r + CNT_ONE;
            carry_r <= c_s;
            p_acc_r <= p_acc_r & p_s;
        end else begin
            a_r     <= a_r;
            b_r     <= b_r;
            work_r  <= work_r;
            cnt_r   <= cnt_r;
            carry_r <= carry_r;
            p_acc_r <= p_acc_r;
        end
    end

    // Result registers update only on the final SHIFT edge and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r   <= '0;
            cout_r  <= 1'b0;
            p_all_r <= 1'b0;
        end else if (last_s) begin
            sum_r   <= work_nx_s;
            cout_r  <= c_s;
            p_all_r <= p_acc_r & p_s;
        end else begin
            sum_r   <= sum_r;
            cout_r  <= cout_r;
            p_all_r <= p_all_r;
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign cout  = cout_r;
    assign p_all = p_all_r;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8): an arithmetic/timing
// reference model checked every cycle, plus directed vectors with literal results.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, p_all;
    logic [W-1:0] sum;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .p_all(p_all)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: an accepted request occupies the adder for W cycles,
    // then the result {cout,sum} = a+b+cin and p_all = &(a^b) appear with done.
    int         m_left;
    logic       m_done, m_cout, m_pall, m_pendp;
    logic [W-1:0] m_sum;
    logic [W:0]   m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0; m_done <= 1'b0; m_sum <= '0; m_cout <= 1'b0; m_pall <= 1'b0;
            m_pend <= '0; m_pendp <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                {m_cout, m_sum} <= m_pend;
                m_pall <= m_pendp;
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_left  <= W;
                m_pend  <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_pendp <= &(a ^ b);
            end
        end
    end

    // Every-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ({busy, done, cout, p_all, sum} !== {(m_left != 0), m_done, m_cout, m_pall, m_sum}) begin
                bad++;
                $display("FAIL model cyc=%0d act busy=%b done=%b cout=%b p=%b sum=%h exp busy=%b done=%b cout=%b p=%b sum=%h",
                         cyc, busy, done, cout, p_all, sum, (m_left != 0), m_done, m_cout, m_pall, m_sum);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Waits for done with a bound; returns the number of edges waited.
    task automatic wait_done(input string nm, output int n);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        if (!done) begin
            bad++;
            total++;
            $display("FAIL %s_timeout act=no_done exp=done", nm);
        end
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic [W-1:0] es, input logic ec, input logic ep);
        int n;
        a = ta; b = tb; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(nm, n);
        chk({nm, "_lat"}, n, 32'd8);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_cout"}, cout, ec);
        chk({nm, "_pall"}, p_all, ep);
    endtask

    initial begin
        int n, bcnt, c1, c2;
        logic [W-1:0] ra, rb;
        logic rc;
        logic [W:0] rs;

        tick(); tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("reset_state", {busy, done, cout, p_all, sum}, 32'd0);

        // Vectors 1-3
        run_op("t1", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b0);
        run_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("t3a", 8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b1);
        run_op("t3b", 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b1);
        tick();
        chk("hold_idle", {done, sum}, {1'b0, 8'hFF});

        // Vector 4: start pulsed mid-SHIFT with new operand is ignored
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        bcnt = 0; n = 0;
        while (!done && n < 20) begin
            if (busy) bcnt++;
            if (n == 3) begin a = 8'hAA; start = 1'b1; end else start = 1'b0;
            tick();
            n++;
        end
        start = 1'b0;
        chk("t4_busy_cycles", bcnt, 32'd8);
        chk("t4_sum", sum, 8'h02);

        // Vector 5: start held high, back-to-back operations
        tick();
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        tick();
        a = 8'h7F; b = 8'h01;
        wait_done("t5a", n);
        c1 = cyc;
        chk("t5a_sum", {cout, sum}, {1'b0, 8'h30});
        tick();
        wait_done("t5b", n);
        c2 = cyc;
        start = 1'b0;
        chk("t5_gap", c2 - c1, 32'd9);
        chk("t5b_sum", {cout, sum}, {1'b0, 8'h80});

        // Vector 6: asynchronous reset in the middle of SHIFT
        tick();
        a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #1 rst_n = 1'b0;
        #1;
        chk("t6_abort", {busy, done, sum}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_done", done, 1'b0);
        run_op("t6_after", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

        // Random operand pairs
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(1, 0));
            rs = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op("rnd", ra, rb, rc, rs[W-1:0], rs[W], &(ra ^ rb));
        end

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
